// File: rtl/vga_xga_timing_gen.sv
// vga_xga_timing_gen: 1024x768@60 raster timing with split x/y position and sticky frame interrupt
module vga_xga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP = 29,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cli,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       interrupt,
  output logic [4:0] x_lo,
  output logic [5:0] x_hi,
  output logic [5:0] y_lo,
  output logic [4:0] y_hi
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [5:0] XH_END = 6'(H_TOTAL / 32 - 1);
  localparam logic [4:0] YH_END = 5'((V_TOTAL - 1) / 48);
  localparam logic [5:0] YL_END = 6'((V_TOTAL - 1) % 48);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic eol, eof, set;
  logic [4:0] nx_lo, ny_hi;
  logic [5:0] nx_hi, ny_lo;
  logic [10:0] nx;
  logic [9:0] ny;
  // next raster position; sync/blank decode this so they line up with the registered x/y
  always_comb begin
    eol = x_hi == XH_END && x_lo == 5'd31;
    eof = eol && y_hi == YH_END && y_lo == YL_END;
    nx_lo = x_lo + 5'd1;
    nx_hi = eol ? 6'd0 : (x_lo == 5'd31 ? x_hi + 6'd1 : x_hi);
    ny_lo = !eol ? y_lo : ((eof || y_lo == 6'd47) ? 6'd0 : y_lo + 6'd1);
    ny_hi = !eol ? y_hi : (eof ? 5'd0 : (y_lo == 6'd47 ? y_hi + 5'd1 : y_hi));
    nx = {nx_hi, nx_lo};
    ny = {ny_hi, 5'd0} + {1'b0, ny_hi, 4'd0} + {4'd0, ny_lo};
    set = nx == 11'd0 && ny == VA;
  end
  // position counters, registered decodes and the sticky interrupt (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lo <= '0;
      x_hi <= '0;
      y_lo <= '0;
      y_hi <= '0;
      blank <= 1'b0;
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
      interrupt <= 1'b0;
    end else begin
      x_lo <= nx_lo;
      x_hi <= nx_hi;
      y_lo <= ny_lo;
      y_hi <= ny_hi;
      blank <= nx >= HA || ny >= VA;
      hsync <= (nx >= HS_START && nx < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= (ny >= VS_START && ny < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
      interrupt <= set ? 1'b1 : (cli ? 1'b0 : interrupt);
    end
  end
endmodule

// File: tb/tb_vga_xga_timing_gen.sv
// tb_vga_xga_timing_gen: directed checks on a full-size instance and a shrunken-frame instance
module tb_vga_xga_timing_gen;
  logic clk = 1'b0, rst_n = 1'b0, cli = 1'b0;
  logic f_hsync, f_vsync, f_blank, f_irq;
  logic [4:0] f_x_lo, f_y_hi;
  logic [5:0] f_x_hi, f_y_lo;
  logic s_hsync, s_vsync, s_blank, s_irq;
  logic [4:0] s_x_lo, s_y_hi;
  logic [5:0] s_x_hi, s_y_lo;
  int checks = 0, errors = 0, cyc = 0;
  int f_hlow = 0, f_blank1 = 0, s_vlow = 0, s_vbad = 0, s_noblank = 0;

  always #5 clk = ~clk;

  vga_xga_timing_gen u_full (
    .clk(clk), .rst_n(rst_n), .cli(1'b0),
    .hsync(f_hsync), .vsync(f_vsync), .blank(f_blank), .interrupt(f_irq),
    .x_lo(f_x_lo), .x_hi(f_x_hi), .y_lo(f_y_lo), .y_hi(f_y_hi)
  );

  // 96-pixel lines, 64-line frames: H active 64, hsync x 72..87; V active 52, vsync y 55..60
  vga_xga_timing_gen #(
    .H_ACTIVE(64), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(52), .V_FP(3), .V_SYNC(6), .V_BP(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .cli(cli),
    .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .interrupt(s_irq),
    .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats;
    f_hlow = 0; f_blank1 = 0; s_vlow = 0; s_vbad = 0; s_noblank = 0;
  endtask

  task automatic run_to(input int t);
    logic pv;
    while (cyc < t) begin
      pv = s_vsync;
      @(posedge clk);
      #1;
      cyc++;
      f_hlow += int'(!f_hsync);
      f_blank1 += int'(f_blank);
      s_vlow += int'(!s_vsync);
      s_noblank += int'(!s_blank);
      if (s_vsync !== pv && (s_x_hi != 0 || s_x_lo != 0)) s_vbad++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_f_pos"}, {f_x_lo, f_x_hi, f_y_lo, f_y_hi}, 0);
    chk({tag, "_f_ctl"}, {f_hsync, f_vsync, f_blank, f_irq}, 4'b1100);
    chk({tag, "_s_pos"}, {s_x_lo, s_x_hi, s_y_lo, s_y_hi}, 0);
    chk({tag, "_s_ctl"}, {s_hsync, s_vsync, s_blank, s_irq}, 4'b1100);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    run_to(1);     chk("f_x1", f_x_lo, 1);
    run_to(32);    chk("f_x32", {f_x_hi, f_x_lo}, {6'd1, 5'd0});
    run_to(1023);  chk("f_blank_1023", f_blank, 0);
    run_to(1024);  chk("f_blank_1024", {f_blank, f_x_hi, f_x_lo}, {1'b1, 6'd32, 5'd0});
    run_to(1047);  chk("f_hs_1047", f_hsync, 1);
    run_to(1048);  chk("f_hs_1048", {f_hsync, f_x_hi, f_x_lo}, {1'b0, 6'd32, 5'd24});
    run_to(1343);  chk("f_eol", {f_x_hi, f_x_lo, f_y_lo, f_hsync}, {6'd41, 5'd31, 6'd0, 1'b1});
    run_to(1344);  chk("f_line1", {f_x_hi, f_x_lo, f_y_lo, f_y_hi, f_blank}, {6'd0, 5'd0, 6'd1, 5'd0, 1'b0});
    clear_stats();
    run_to(2688);
    chk("f_hs_width", f_hlow, 136);
    chk("f_blank_width", f_blank1, 320);
    chk("f_line2", {f_x_hi, f_x_lo, f_y_lo}, {6'd0, 5'd0, 6'd2});
    chk("f_irq_idle", f_irq, 0);
    run_to(4607);  chk("s_y47_eol", {s_y_hi, s_y_lo, s_x_hi, s_x_lo}, {5'd0, 6'd47, 6'd2, 5'd31});
    run_to(4608);  chk("s_y48", {s_y_hi, s_y_lo, s_x_hi, s_x_lo}, {5'd1, 6'd0, 6'd0, 5'd0});
    run_to(4991);  chk("s_pre_set", {s_irq, s_blank}, 2'b01);
    run_to(4992);  chk("s_set", {s_irq, s_y_hi, s_y_lo, s_vsync, s_blank}, {1'b1, 5'd1, 6'd4, 1'b1, 1'b1});
    clear_stats();
    run_to(5600);  chk("s_irq_hold", s_irq, 1);
    cli = 1'b1;
    run_to(5601);
    cli = 1'b0;
    chk("s_irq_clear", s_irq, 0);
    run_to(6143);
    chk("s_vs_width", s_vlow, 576);
    chk("s_vs_only_x0", s_vbad, 0);
    chk("s_vblank_all", s_noblank, 0);
    chk("s_eof", {s_y_hi, s_y_lo, s_x_hi, s_x_lo, s_vsync}, {5'd1, 6'd15, 6'd2, 5'd31, 1'b1});
    run_to(6144);  chk("s_wrap", {s_y_hi, s_y_lo, s_x_hi, s_x_lo, s_blank, s_irq}, 0);
    cli = 1'b1;
    run_to(6145);
    cli = 1'b0;
    chk("s_cli_idle", s_irq, 0);
    run_to(11135); chk("s_pre_set2", s_irq, 0);
    cli = 1'b1;
    run_to(11136);
    cli = 1'b0;
    chk("s_set_wins", s_irq, 1);
    run_to(11137); chk("s_set_wins_hold", s_irq, 1);
    run_to(14000); chk("s_mid", {s_irq, s_y_hi, s_y_lo, s_x_hi, s_x_lo}, {1'b1, 5'd0, 6'd17, 6'd2, 5'd16});
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    run_to(1);     chk("re_x1", {f_x_lo, s_x_lo}, {5'd1, 5'd1});
    run_to(4992);  chk("re_set", {s_irq, s_y_hi, s_y_lo}, {1'b1, 5'd1, 6'd4});
    run_to(6144);  chk("re_wrap", {s_y_hi, s_y_lo, s_x_hi, s_x_lo}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_xga_timing_gen.md
Name: vga_xga_timing_gen

Overview:
- Raster timing generator for the TinyQV VGA text console peripheral: 1024x768 @ ~60 Hz from the 64 MHz project clock.
- Produces hsync, vsync and blank, plus the pixel position in split form (x = x_hi*32 + x_lo, y = y_hi*48 + y_lo) so the character renderer downstream needs no divider.
- Raises a frame interrupt at the start of vertical blanking; the host clears it by reading the peripheral's VGA register.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 160, horizontal back porch (pixels); H_TOTAL = 1344, must be a multiple of 32
V_ACTIVE, 768, visible lines
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = 806
H_SYNC_POL, 0, hsync active level (0 = active low)
V_SYNC_POL, 0, vsync active level (0 = active low)

Ports:
clk  input  1  project clock, 64 MHz
rst_n  input  1  asynchronous active-low reset
cli  input  1  interrupt clear strobe, sampled on clk
hsync  output  1  horizontal sync pin level
vsync  output  1  vertical sync pin level
blank  output  1  1 outside the 1024x768 active area
interrupt  output  1  frame interrupt, level, sticky
x_lo  output  5  x mod 32
x_hi  output  6  x div 32, range 0..41
y_lo  output  6  y mod 48, range 0..47
y_hi  output  5  y div 48, range 0..16

Behaviour:
- Reset is asynchronous on rst_n low. Every output is a flop.
  - Reset values: x_lo=0, x_hi=0, y_lo=0, y_hi=0, blank=0, interrupt=0.
  - hsync = ~H_SYNC_POL and vsync = ~V_SYNC_POL (inactive levels).
- Reset may assert at any point in a frame; outputs return to the reset values immediately.
- Counting starts on the first clk edge after rst_n deasserts.
- Counting advances one pixel per clk and never stalls.
- x_lo increments every cycle. On 31 it wraps to 0 and x_hi increments.
- End of line is x_hi==H_TOTAL/32-1 and x_lo==31 (x=1343). The next cycle sets x=0 and advances y.
- y advance: y_lo increments. On 47 it wraps to 0 and y_hi increments.
- End of frame is y == V_TOTAL-1 (y_hi==16, y_lo==37) at end of line. The next cycle sets x=0, y=0.
- hsync, vsync and blank are registered decodes of the next position. They always describe the position currently on x/y outputs, with zero relative skew.
- blank = (x >= H_ACTIVE) | (y >= V_ACTIVE).
- hsync = H_SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (1048..1183), else ~H_SYNC_POL.
- vsync = V_SYNC_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (771..776), else ~V_SYNC_POL. vsync changes only with the line change (x=0).
- Interrupt:
  - Set event is the cycle in which the outputs first show x=0, y=V_ACTIVE (768). interrupt reads 1 on that same cycle.
  - interrupt stays 1 until a cycle with cli=1; it reads 0 from the following cycle.
  - If cli and the set event coincide, set wins and interrupt stays 1.
  - cli while interrupt=0 has no effect.
  - Exactly one set event per frame.
- Comparisons use full-width x (11 bits) and y (10 bits) reconstructed internally, or equivalent per-field compares. Any implementation is acceptable provided outputs match bit-exactly.
- No write or config interface; timing is fixed by parameters at elaboration.

Test Plan:
- Hold rst_n low, toggle clk -> x_lo/x_hi/y_lo/y_hi=0, blank=0, hsync=1, vsync=1, interrupt=0. Release -> cycle 1 shows x_lo=1, cycle 32 shows x_lo=0, x_hi=1.
- Run one line -> blank rises at x=1024 (x_hi=32, x_lo=0). hsync low for exactly 136 cycles starting at x=1048 (x_hi=32, x_lo=24). x=1343 followed by x=0, y=1. Line period 1344 cycles.
- Run to y=47 end of line -> next is y_lo=0, y_hi=1. At y=805 end of line -> next is x=0, y=0. Frame period 1344*806 = 1,083,264 cycles.
- Check vsync low exactly for lines 771..776, transitioning only when x=0. blank=1 for all of lines 768..805.
- Check interrupt rises when y=768, x=0 and stays high through the frame with cli=0. Pulse cli at y=780 -> interrupt 0 next cycle. Assert cli exactly at the set cycle of the next frame -> interrupt remains 1.
- Assert rst_n low asynchronously mid-clock at y=400, x=700 -> outputs go to reset values before the next clk edge, interrupt=0. Release -> counting restarts from (0,0) and the full frame timing repeats.
